cvp14_mem_responder: RTL and testbench
======================================

CVP14_MEM_RESPONDER -- requirements
Module: cvp14_mem_responder

Interface
REQ-001 The block SHALL run on one clock and use a synchronous, active-high reset, with the ports named Clk1 and Reset.
REQ-002 Parameter AW SHALL default to 10 and set the implemented word-address width (1024 x 16-bit words).
REQ-003 Parameter BLEN SHALL default to 16 and set the vector burst length in beats (one 256-bit vector).
REQ-004 Clk1  input  1  clock; all state SHALL update on the rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Addr  input  16  word address from the CVP14 initiator.
REQ-007 RD  input  1  read strobe.
REQ-008 WR  input  1  write strobe.
REQ-009 V  input  1  vector-access qualifier; high on every beat of a vector burst.
REQ-010 DataIn  input  16  write data from the initiator.
REQ-011 DataOut  output  16  registered read data to the initiator.
REQ-012 BurstActive  output  1  high while a vector burst is in progress.
REQ-013 BeatCnt  output  4  index of the next expected burst beat.
REQ-014 BurstDone  output  1  one-cycle pulse after the final burst beat completes.
REQ-015 AddrErr  output  1  one-cycle pulse for an access with Addr[15:AW] != 0.
REQ-016 SeqErr  output  1  sticky burst-protocol violation flag.
REQ-017 Collision  output  1  sticky flag set when RD and WR are both high.

Function
REQ-018 Single access: RD=1, WR=0 at edge N SHALL drive DataOut = mem[Addr] from edge N to edge N+1 (read latency 1 cycle).
REQ-019 DataOut SHALL hold its last value on cycles with no valid read.
REQ-020 Write: WR=1, RD=0 at edge N SHALL update mem[Addr] with DataIn at edge N; a read of the same address at edge N+1 SHALL return the new value.
REQ-021 Out of range (Addr[15:AW] != 0): a read SHALL return 16'hFFFF, a write SHALL leave memory unchanged, and AddrErr SHALL pulse high for the following cycle.
REQ-022 RD=1 and WR=1 together: memory and DataOut SHALL stay unchanged, and Collision SHALL set and remain set until Reset.
REQ-023 The burst tracker SHALL use the states IDLE, RBURST and WBURST.
REQ-024 IDLE -> RBURST on RD & V, and IDLE -> WBURST on WR & V; the block SHALL latch Base = Addr, and BeatCnt SHALL become 1.
REQ-025 In a burst, an expected beat is V=1, the same strobe only, and Addr == (Base + BeatCnt) mod 2^16; each expected beat SHALL increment BeatCnt.
REQ-026 When the beat with index BLEN-1 is accepted, the tracker SHALL return to IDLE, BeatCnt SHALL become 0, and BurstDone SHALL pulse for one cycle.
REQ-027 Any other input in a burst (idle cycle, V low, wrong strobe, non-contiguous address) SHALL set SeqErr, return the tracker to IDLE and clear BeatCnt.
REQ-028 When REQ-027 applies, the memory access on that cycle SHALL still follow REQ-018 to REQ-022, and the tracker SHALL NOT restart on that same cycle.
REQ-029 A burst crossing into the out-of-range space SHALL continue to be tracked, with AddrErr pulsing once per out-of-range beat.
REQ-030 Accesses with V=0 in IDLE SHALL NOT affect the tracker.
REQ-031 BurstActive SHALL equal (state != IDLE).

Reset
REQ-032 When Reset=1 at an edge, the block SHALL set DataOut=0, state=IDLE, BeatCnt=0, and BurstDone=AddrErr=SeqErr=Collision=0.
REQ-033 Reset SHALL take priority over all accesses on the same edge; any RD or WR on that edge SHALL be ignored.
REQ-034 Memory contents SHALL be unaffected by Reset and undefined until written.
REQ-035 Reset during a burst SHALL abort the burst without setting SeqErr.

Verification
REQ-036 Write/read: write 16'hBEEF to 0x0005, then read 0x0005 on the next cycle -> DataOut=16'hBEEF one cycle after the read.
REQ-037 Vector read burst: 16 beats with RD & V at 0x0100..0x010F -> BeatCnt steps 1..15 then 0, BurstDone pulses once, SeqErr=0.
REQ-038 Broken burst: WR & V at 0x0020, 0x0021, 0x0023 -> SeqErr=1, state=IDLE, and 0x0023 is still written.
REQ-039 Collision and range: RD=WR=1 at 0x0000 -> Collision=1 and DataOut unchanged; read 0x8000 -> DataOut=16'hFFFF with a one-cycle AddrErr pulse.
REQ-040 Reset mid-burst: Reset at beat 7 of a VLD -> all outputs at reset values, SeqErr=0, and a new burst is accepted on the next cycle.

Source files
------------

// File: rtl/cvp14_mem_responder.sv
// CVP14 memory responder: a 2^AW x 16-bit word memory with a registered read
// port, an out-of-range address check, RD/WR collision detection and a
// tracker that follows contiguous vector bursts and flags protocol errors.
module cvp14_mem_responder #(
  parameter int AW   = 10,
  parameter int BLEN = 16
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic [15:0] Addr,
  input  logic        RD,
  input  logic        WR,
  input  logic        V,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        BurstActive,
  output logic [3:0]  BeatCnt,
  output logic        BurstDone,
  output logic        AddrErr,
  output logic        SeqErr,
  output logic        Collision
);

  typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_e;

  localparam int          DEPTH     = 1 << AW;
  localparam logic [3:0]  LAST_BEAT = 4'(BLEN - 1);

  logic [15:0] mem_q [DEPTH];

  state_e      state_q;
  logic [15:0] base_q;
  logic [3:0]  beat_q;
  logic        done_q;
  logic        seq_err_q;
  logic [15:0] data_out_q;
  logic        addr_err_q;
  logic        collision_q;

  // Decoded access type and the address the next burst beat must carry.
  logic          rd_only;
  logic          wr_only;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic [15:0]   exp_addr;
  logic          beat_ok;

  // Classify the current access and decide whether it continues the burst.
  always_comb begin
    rd_only  = RD & ~WR;
    wr_only  = WR & ~RD;
    in_range = (Addr >> AW) == 16'd0;
    word_idx = Addr[AW-1:0];
    exp_addr = base_q + {12'd0, beat_q};
    beat_ok  = V && (Addr == exp_addr) &&
               (((state_q == RBURST) && rd_only) ||
                ((state_q == WBURST) && wr_only));
  end

  // Memory array write port; out-of-range and colliding writes are dropped.
  // NOTE: the array has no reset branch on purpose -- contents survive Reset
  // and a reset loop over every word would stop it mapping onto RAM.
  always_ff @(posedge Clk1) begin
    if (!Reset && wr_only && in_range) begin
      mem_q[word_idx] <= DataIn;
    end
  end

  // Read data register plus the address-error pulse and sticky collision flag.
  // NOTE: every register here is assigned with <= so all of them sample the
  // same pre-edge values; blocking assignments would create ordering races.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      data_out_q  <= 16'h0000;
      addr_err_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      addr_err_q <= (rd_only | wr_only) & ~in_range;
      if (rd_only) begin
        data_out_q <= in_range ? mem_q[word_idx] : 16'hFFFF;
      end
      if (RD && WR) begin
        collision_q <= 1'b1;
      end
    end
  end

  // Burst tracker: starts on a vector strobe in IDLE, counts contiguous beats,
  // pulses BurstDone after the last one and aborts with SeqErr otherwise.
  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q   <= IDLE;
      base_q    <= 16'h0000;
      beat_q    <= 4'd0;
      done_q    <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (V && rd_only) begin
            state_q <= RBURST;
            base_q  <= Addr;
            beat_q  <= 4'd1;
          end else if (V && wr_only) begin
            state_q <= WBURST;
            base_q  <= Addr;
            beat_q  <= 4'd1;
          end
        end
        RBURST, WBURST: begin
          if (beat_ok) begin
            if (beat_q == LAST_BEAT) begin
              state_q <= IDLE;
              beat_q  <= 4'd0;
              done_q  <= 1'b1;
            end else begin
              beat_q <= beat_q + 4'd1;
            end
          end else begin
            // A broken burst never restarts on the same cycle.
            state_q   <= IDLE;
            beat_q    <= 4'd0;
            seq_err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          beat_q  <= 4'd0;
        end
      endcase
    end
  end

  assign DataOut     = data_out_q;
  assign BurstActive = (state_q != IDLE);
  assign BeatCnt     = beat_q;
  assign BurstDone   = done_q;
  assign AddrErr     = addr_err_q;
  assign SeqErr      = seq_err_q;
  assign Collision   = collision_q;

endmodule

// File: tb/tb_cvp14_mem_responder.sv
// Directed bench for cvp14_mem_responder: single accesses, a full vector
// read burst, a broken write burst, collision, out-of-range accesses and
// reset behaviour, all against hand-computed expected values.
module tb_cvp14_mem_responder;

  logic        Clk1 = 1'b0;
  logic        Reset;
  logic [15:0] Addr;
  logic        RD;
  logic        WR;
  logic        V;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        BurstActive;
  logic [3:0]  BeatCnt;
  logic        BurstDone;
  logic        AddrErr;
  logic        SeqErr;
  logic        Collision;

  int tests_run    = 0;
  int tests_failed = 0;

  cvp14_mem_responder #(.AW(10), .BLEN(16)) dut (
    .Clk1        (Clk1),
    .Reset       (Reset),
    .Addr        (Addr),
    .RD          (RD),
    .WR          (WR),
    .V           (V),
    .DataIn      (DataIn),
    .DataOut     (DataOut),
    .BurstActive (BurstActive),
    .BeatCnt     (BeatCnt),
    .BurstDone   (BurstDone),
    .AddrErr     (AddrErr),
    .SeqErr      (SeqErr),
    .Collision   (Collision)
  );

  always #5 Clk1 = ~Clk1;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, clock it in, then sample 1 ns after the edge.
  task automatic step(input logic rst, input logic rd, input logic wr, input logic v,
                      input logic [15:0] a, input logic [15:0] d);
    Reset  = rst;
    RD     = rd;
    WR     = wr;
    V      = v;
    Addr   = a;
    DataIn = d;
    @(posedge Clk1);
    #1;
  endtask

  initial begin
    Reset = 1'b1; RD = 1'b0; WR = 1'b0; V = 1'b0; Addr = '0; DataIn = '0;

    // Reset state
    step(1, 0, 0, 0, 16'h0000, 16'h0000);
    check("rst_dout",   DataOut,     16'h0000);
    check("rst_active", BurstActive, 16'd0);
    check("rst_beat",   BeatCnt,     16'd0);
    check("rst_done",   BurstDone,   16'd0);
    check("rst_aerr",   AddrErr,     16'd0);
    check("rst_seq",    SeqErr,      16'd0);
    check("rst_coll",   Collision,   16'd0);

    // Write BEEF to 0x0005, then read it back on the next cycle
    step(0, 0, 1, 0, 16'h0005, 16'hBEEF);
    check("wr_dout_hold", DataOut, 16'h0000);
    step(0, 1, 0, 0, 16'h0005, 16'h0000);
    check("rd_beef", DataOut, 16'hBEEF);
    step(0, 0, 0, 0, 16'h0000, 16'h0000);
    check("idle_hold", DataOut, 16'hBEEF);

    // Preload 0x0100..0x010F with non-vector writes; tracker must stay idle
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0, 16'h0100 + 16'(i), 16'h1000 + 16'(i));
    end
    check("novec_idle", BurstActive, 16'd0);
    check("novec_beat", BeatCnt,     16'd0);

    // Full 16-beat vector read burst
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 1, 16'h0100 + 16'(i), 16'h0000);
      check($sformatf("rb_beat%0d", i),   BeatCnt,     16'((i + 1) % 16));
      check($sformatf("rb_active%0d", i), BurstActive, (i < 15) ? 16'd1 : 16'd0);
      check($sformatf("rb_done%0d", i),   BurstDone,   (i == 15) ? 16'd1 : 16'd0);
      check($sformatf("rb_data%0d", i),   DataOut,     16'h1000 + 16'(i));
    end
    step(0, 0, 0, 0, 16'h0000, 16'h0000);
    check("rb_done_clear", BurstDone, 16'd0);
    check("rb_seq",        SeqErr,    16'd0);

    // Broken write burst: 0x20, 0x21, then 0x23
    step(0, 0, 1, 1, 16'h0020, 16'h00A0);
    step(0, 0, 1, 1, 16'h0021, 16'h00A1);
    check("wb_beat2", BeatCnt, 16'd2);
    step(0, 0, 1, 1, 16'h0023, 16'h00A3);
    check("wb_seq",    SeqErr,      16'd1);
    check("wb_idle",   BurstActive, 16'd0);
    check("wb_beat0",  BeatCnt,     16'd0);
    step(0, 1, 0, 0, 16'h0023, 16'h0000);
    check("wb_written", DataOut, 16'h00A3);
    step(0, 1, 0, 0, 16'h0021, 16'h0000);
    check("wb_beat1_data", DataOut, 16'h00A1);

    // Collision at 0x0000 leaves memory and DataOut unchanged
    step(0, 0, 1, 0, 16'h0000, 16'h1111);
    step(0, 1, 1, 0, 16'h0000, 16'h2222);
    check("coll_flag", Collision, 16'd1);
    check("coll_dout", DataOut,   16'h00A1);
    step(0, 1, 0, 0, 16'h0000, 16'h0000);
    check("coll_mem",    DataOut,   16'h1111);
    check("coll_sticky", Collision, 16'd1);

    // Out-of-range read and write
    step(0, 1, 0, 0, 16'h8000, 16'h0000);
    check("oor_rd_data", DataOut, 16'hFFFF);
    check("oor_rd_aerr", AddrErr, 16'd1);
    step(0, 0, 0, 0, 16'h0000, 16'h0000);
    check("oor_aerr_pulse", AddrErr, 16'd0);
    step(0, 0, 1, 0, 16'h0405, 16'h5555);
    check("oor_wr_aerr", AddrErr, 16'd1);
    step(0, 1, 0, 0, 16'h0005, 16'h0000);
    check("oor_no_alias", DataOut, 16'hBEEF);
    check("inr_aerr",     AddrErr, 16'd0);
    check("seq_sticky",   SeqErr,  16'd1);

    // Reset at beat 7 of a vector read burst
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 0, 1, 16'h0100 + 16'(i), 16'h0000);
    end
    check("mb_beat7", BeatCnt, 16'd7);
    step(1, 1, 0, 1, 16'h0107, 16'h0000);
    check("mb_dout",   DataOut,     16'h0000);
    check("mb_active", BurstActive, 16'd0);
    check("mb_beat",   BeatCnt,     16'd0);
    check("mb_seq",    SeqErr,      16'd0);
    check("mb_coll",   Collision,   16'd0);
    check("mb_done",   BurstDone,   16'd0);
    step(0, 1, 0, 1, 16'h0200, 16'h0000);
    check("mb_restart_active", BurstActive, 16'd1);
    check("mb_restart_beat",   BeatCnt,     16'd1);
    // Idle cycle inside a burst is a protocol error
    step(0, 0, 0, 0, 16'h0000, 16'h0000);
    check("idle_in_burst_seq",  SeqErr,      16'd1);
    check("idle_in_burst_idle", BurstActive, 16'd0);

    // Write during Reset is ignored
    step(1, 0, 1, 0, 16'h0005, 16'hDEAD);
    step(0, 1, 0, 0, 16'h0005, 16'h0000);
    check("rst_wr_ignored", DataOut, 16'hBEEF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
